// File: rtl/decoder_pkg.sv
// Shared definitions for the RV32I decode stage.
//   - major opcode encodings (OP_*)
//   - bit positions of the one-hot instruction class vector (CLS_*)
//   - immediate-format enum and the helper that assembles a raw 32-bit
//     immediate for a given format
//   - funct7 / funct3 constants used by the legality checks
package decoder_pkg;

  localparam logic [6:0] OP_ALU_REG = 7'b0110011;
  localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OP_FENCE   = 7'b0001111;

  localparam int unsigned CLS_ALU_REG = 0;
  localparam int unsigned CLS_ALU_IMM = 1;
  localparam int unsigned CLS_BRANCH  = 2;
  localparam int unsigned CLS_JALR    = 3;
  localparam int unsigned CLS_JAL     = 4;
  localparam int unsigned CLS_AUIPC   = 5;
  localparam int unsigned CLS_LUI     = 6;
  localparam int unsigned CLS_LOAD    = 7;
  localparam int unsigned CLS_STORE   = 8;
  localparam int unsigned CLS_SYSTEM  = 9;
  localparam int unsigned NUM_CLS     = 10;

  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  // Raw 32-bit immediate, already sign-extended from instr[31] to 32 bits.
  function automatic logic [31:0] imm32(input logic [31:0] instr, input imm_fmt_e fmt);
    logic [31:0] r;
    r = '0;
    case (fmt)
      IMM_I:   r = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   r = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   r = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   r = {instr[31:12], 12'b0};
      IMM_J:   r = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Handshake bundle between fetch, the decode stage and execute.
//   in_*  : fetch -> decode (valid/ready, instruction word, PC)
//   out_* : decode -> execute (valid/ready, registered decoded fields)
// Modports: slave = the decode stage, master = the environment around it.
// Optional: DECODE_M_EXT_EN adds out_is_muldiv.
interface decode_stage_if
  import decoder_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32
) ();

  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_instr;
  logic [PC_W-1:0]    in_pc;

  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [NUM_CLS-1:0] out_class;
  logic [4:0]         out_rd;
  logic [4:0]         out_rs1;
  logic [4:0]         out_rs2;
  logic [2:0]         out_funct3;
  logic [6:0]         out_funct7;
  logic [XLEN-1:0]    out_imm;
  logic               out_rd_we;
  logic               out_illegal;
`ifdef DECODE_M_EXT_EN
  logic               out_is_muldiv;
`endif

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_class, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_rd_we, out_illegal
`ifdef DECODE_M_EXT_EN
    , output out_is_muldiv
`endif
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_class, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_rd_we, out_illegal
`ifdef DECODE_M_EXT_EN
    , input out_is_muldiv
`endif
  );

endinterface

// File: rtl/decode_comb.sv
// Purely combinational RV32I decoder core.
//   instr      : raw instruction word
//   cls        : one-hot class (all zero when illegal)
//   rd/rs1/rs2/funct3/funct7 : raw field extraction
//   imm        : format-selected immediate, sign-extended to XLEN
//   rd_we      : instruction writes a non-zero rd
//   illegal    : encoding not accepted
//   is_muldiv  : only with DECODE_M_EXT_EN; RV32M register-register op
module decode_comb
  import decoder_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]        instr,
  output logic [NUM_CLS-1:0] cls,
  output logic [4:0]         rd,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [2:0]         funct3,
  output logic [6:0]         funct7,
  output logic [XLEN-1:0]    imm,
  output logic               rd_we,
  output logic               illegal
`ifdef DECODE_M_EXT_EN
  , output logic             is_muldiv
`endif
);

  logic [6:0] opcode;
  imm_fmt_e   fmt;
  logic       writes_rd;
  logic       muldiv;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  always_comb begin
    cls       = '0;
    fmt       = IMM_NONE;
    writes_rd = 1'b0;
    illegal   = 1'b0;
    muldiv    = 1'b0;

    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opcode)
        OP_ALU_REG: begin
          cls[CLS_ALU_REG] = 1'b1;
          writes_rd        = 1'b1;
`ifdef DECODE_M_EXT_EN
          if (funct7 == F7_MULDIV) muldiv = 1'b1;
          else
`endif
          if (funct7 == F7_ALT)
            illegal = !(funct3 inside {F3_ADD_SUB, F3_SRL_SRA});
          else if (funct7 != F7_ZERO)
            illegal = 1'b1;
        end
        OP_ALU_IMM: begin
          cls[CLS_ALU_IMM] = 1'b1;
          fmt              = IMM_I;
          writes_rd        = 1'b1;
          // Shift-immediates reuse instr[31:25] as funct7; all other
          // funct3 values treat those bits as immediate.
          if (funct3 == F3_SLL && funct7 != F7_ZERO)
            illegal = 1'b1;
          if (funct3 == F3_SRL_SRA && !(funct7 inside {F7_ZERO, F7_ALT}))
            illegal = 1'b1;
        end
        OP_FENCE: begin
          // Treated as a non-writing ALU_IMM so execute sees a no-op.
          cls[CLS_ALU_IMM] = 1'b1;
          fmt              = IMM_I;
        end
        OP_BRANCH: begin
          cls[CLS_BRANCH] = 1'b1;
          fmt             = IMM_B;
          illegal         = funct3 inside {3'b010, 3'b011};
        end
        OP_JALR: begin
          cls[CLS_JALR] = 1'b1;
          fmt           = IMM_I;
          writes_rd     = 1'b1;
          illegal       = (funct3 != 3'b000);
        end
        OP_JAL: begin
          cls[CLS_JAL] = 1'b1;
          fmt          = IMM_J;
          writes_rd    = 1'b1;
        end
        OP_AUIPC: begin
          cls[CLS_AUIPC] = 1'b1;
          fmt            = IMM_U;
          writes_rd      = 1'b1;
        end
        OP_LUI: begin
          cls[CLS_LUI] = 1'b1;
          fmt          = IMM_U;
          writes_rd    = 1'b1;
        end
        OP_LOAD: begin
          cls[CLS_LOAD] = 1'b1;
          fmt           = IMM_I;
          writes_rd     = 1'b1;
          illegal       = funct3 inside {3'b011, 3'b110, 3'b111};
        end
        OP_STORE: begin
          cls[CLS_STORE] = 1'b1;
          fmt            = IMM_S;
          illegal        = (funct3 >= 3'b011);
        end
        OP_SYSTEM: begin
          cls[CLS_SYSTEM] = 1'b1;
          fmt             = IMM_I;
        end
        default: illegal = 1'b1;
      endcase
    end

    if (illegal) begin
      cls       = '0;
      fmt       = IMM_NONE;
      writes_rd = 1'b0;
      muldiv    = 1'b0;
    end
  end

  assign rd_we = writes_rd && (rd != 5'd0);
  assign imm   = XLEN'($signed(imm32(instr, fmt)));

`ifdef DECODE_M_EXT_EN
  assign is_muldiv = muldiv;
`else
  logic unused_muldiv;
  assign unused_muldiv = muldiv;
`endif

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with valid/ready on both sides.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   flush       : drop the held bundle and any instruction offered this cycle
//   bus         : decode_stage_if slave (fetch input channel, decoded output)
//   decode_cnt  : number of bundles delivered downstream (wraps)
// Optional: DECODE_M_EXT_EN accepts RV32M and drives bus.out_is_muldiv.
module decode_stage
  import decoder_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  decode_stage_if.slave    bus,
  output logic [CNT_W-1:0] decode_cnt
);

  logic [NUM_CLS-1:0] d_cls;
  logic [4:0]         d_rd, d_rs1, d_rs2;
  logic [2:0]         d_funct3;
  logic [6:0]         d_funct7;
  logic [XLEN-1:0]    d_imm;
  logic               d_rd_we, d_illegal;

  logic               valid_q;
  logic [PC_W-1:0]    pc_q;
  logic [NUM_CLS-1:0] cls_q;
  logic [4:0]         rd_q, rs1_q, rs2_q;
  logic [2:0]         funct3_q;
  logic [6:0]         funct7_q;
  logic [XLEN-1:0]    imm_q;
  logic               rd_we_q, illegal_q;
  logic [CNT_W-1:0]   cnt_q;

  logic in_ready;
  logic accept;
  logic deliver;

`ifdef DECODE_M_EXT_EN
  logic d_muldiv;
  logic muldiv_q;
`endif

  decode_comb #(.XLEN(XLEN)) u_decode_comb (
    .instr     (bus.in_instr),
    .cls       (d_cls),
    .rd        (d_rd),
    .rs1       (d_rs1),
    .rs2       (d_rs2),
    .funct3    (d_funct3),
    .funct7    (d_funct7),
    .imm       (d_imm),
    .rd_we     (d_rd_we),
    .illegal   (d_illegal)
`ifdef DECODE_M_EXT_EN
    , .is_muldiv (d_muldiv)
`endif
  );

  // Single output register, no skid buffer: a new word can only enter
  // when the slot is empty or is being drained this same cycle.
  assign in_ready = !valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready && !flush;
  assign deliver  = valid_q && bus.out_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      cls_q     <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      funct3_q  <= '0;
      funct7_q  <= '0;
      imm_q     <= '0;
      rd_we_q   <= 1'b0;
      illegal_q <= 1'b0;
`ifdef DECODE_M_EXT_EN
      muldiv_q  <= 1'b0;
`endif
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q   <= 1'b1;
      pc_q      <= bus.in_pc;
      cls_q     <= d_cls;
      rd_q      <= d_rd;
      rs1_q     <= d_rs1;
      rs2_q     <= d_rs2;
      funct3_q  <= d_funct3;
      funct7_q  <= d_funct7;
      imm_q     <= d_imm;
      rd_we_q   <= d_rd_we;
      illegal_q <= d_illegal;
`ifdef DECODE_M_EXT_EN
      muldiv_q  <= d_muldiv;
`endif
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          cnt_q <= '0;
    else if (deliver) cnt_q <= cnt_q + 1'b1;
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = valid_q;
  assign bus.out_pc      = pc_q;
  assign bus.out_class   = cls_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_rs1     = rs1_q;
  assign bus.out_rs2     = rs2_q;
  assign bus.out_funct3  = funct3_q;
  assign bus.out_funct7  = funct7_q;
  assign bus.out_imm     = imm_q;
  assign bus.out_rd_we   = rd_we_q;
  assign bus.out_illegal = illegal_q;
`ifdef DECODE_M_EXT_EN
  assign bus.out_is_muldiv = muldiv_q;
`endif
  assign decode_cnt      = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [CNT_W-1:0] decode_cnt;

  int          checks  = 0;
  int          errors  = 0;
  int unsigned exp_cnt = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [9:0]  cls;
    logic [31:0] imm;
    logic        rd_we;
    logic        ill;
  } vec_t;

  decode_stage_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();

  decode_stage #(.XLEN(XLEN), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .bus        (bus),
    .decode_cnt (decode_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_class !== 10'h000) begin errors++; $display("FAIL reset_class got %h want 000", bus.out_class); end
    checks++; if (bus.out_imm !== '0) begin errors++; $display("FAIL reset_imm got %h want 0", bus.out_imm); end
    checks++; if (decode_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d want 0", decode_cnt); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_addi;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_instr = 32'h00500093; bus.in_pc = 32'h100;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %b want 1", bus.out_valid); end
    checks++; if (bus.out_class !== 10'h002) begin errors++; $display("FAIL addi_class got %h want 002", bus.out_class); end
    checks++; if (bus.out_rd !== 5'd1) begin errors++; $display("FAIL addi_rd got %0d want 1", bus.out_rd); end
    checks++; if (bus.out_rs1 !== 5'd0) begin errors++; $display("FAIL addi_rs1 got %0d want 0", bus.out_rs1); end
    checks++; if (bus.out_imm !== XLEN'(32'd5)) begin errors++; $display("FAIL addi_imm got %h want 5", bus.out_imm); end
    checks++; if (bus.out_rd_we !== 1'b1) begin errors++; $display("FAIL addi_rd_we got %b want 1", bus.out_rd_we); end
    checks++; if (bus.out_illegal !== 1'b0) begin errors++; $display("FAIL addi_illegal got %b want 0", bus.out_illegal); end
    checks++; if (bus.out_pc !== 32'h100) begin errors++; $display("FAIL addi_pc got %h want 100", bus.out_pc); end
    checks++; if (decode_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL addi_cnt_pre got %0d want %0d", decode_cnt, exp_cnt); end
    tick();
    exp_cnt++;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain got %b want 0", bus.out_valid); end
    checks++; if (decode_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL addi_cnt got %0d want %0d", decode_cnt, exp_cnt); end
  endtask

  task automatic test_formats;
    vec_t tbl [10];
    tbl[0] = '{32'hFFDFF0EF, 10'h010, 32'hFFFFFFFC, 1'b1, 1'b0}; // jal x1,-4
    tbl[1] = '{32'hFE20AE23, 10'h100, 32'hFFFFFFFC, 1'b0, 1'b0}; // sw x2,-4(x1)
    tbl[2] = '{32'hFE208CE3, 10'h004, 32'hFFFFFFF8, 1'b0, 1'b0}; // beq x1,x2,-8
    tbl[3] = '{32'h123452B7, 10'h040, 32'h12345000, 1'b1, 1'b0}; // lui x5,0x12345
    tbl[4] = '{32'h80000017, 10'h020, 32'h80000000, 1'b0, 1'b0}; // auipc x0 (rd=0)
    tbl[5] = '{32'hFFF12303, 10'h080, 32'hFFFFFFFF, 1'b1, 1'b0}; // lw x6,-1(x2)
    tbl[6] = '{32'h010280E7, 10'h008, 32'h00000010, 1'b1, 1'b0}; // jalr x1,16(x5)
    tbl[7] = '{32'h0FF0000F, 10'h002, 32'h000000FF, 1'b0, 1'b0}; // fence
    tbl[8] = '{32'h00000073, 10'h200, 32'h00000000, 1'b0, 1'b0}; // ecall
    tbl[9] = '{32'h4030D093, 10'h002, 32'h00000403, 1'b1, 1'b0}; // srai x1,x1,3
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1; bus.in_instr = tbl[i].instr; bus.in_pc = 32'h200 + 32'(i * 4);
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.out_class !== tbl[i].cls) begin errors++; $display("FAIL fmt%0d_class got %h want %h", i, bus.out_class, tbl[i].cls); end
      checks++; if (bus.out_imm !== XLEN'(tbl[i].imm)) begin errors++; $display("FAIL fmt%0d_imm got %h want %h", i, bus.out_imm, tbl[i].imm); end
      checks++; if (bus.out_rd_we !== tbl[i].rd_we) begin errors++; $display("FAIL fmt%0d_rd_we got %b want %b", i, bus.out_rd_we, tbl[i].rd_we); end
      checks++; if (bus.out_illegal !== tbl[i].ill) begin errors++; $display("FAIL fmt%0d_illegal got %b want %b", i, bus.out_illegal, tbl[i].ill); end
      checks++; if (bus.out_pc !== 32'h200 + 32'(i * 4)) begin errors++; $display("FAIL fmt%0d_pc got %h", i, bus.out_pc); end
      tick();
      exp_cnt++;
    end
    checks++; if (decode_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL fmt_cnt got %0d want %0d", decode_cnt, exp_cnt); end
  endtask

  task automatic test_illegal;
    logic [31:0] tbl [8];
    tbl[0] = 32'h00000000; // instr[1:0] != 11
    tbl[1] = 32'h0000007F; // unknown opcode
    tbl[2] = 32'h0020B023; // store funct3=011
    tbl[3] = 32'h0020A063; // branch funct3=010
    tbl[4] = 32'h402090B3; // funct7=0100000 with funct3=001, rd=1
    tbl[5] = 32'h40109093; // slli with funct7=0100000
    tbl[6] = 32'h000090E7; // jalr funct3=001
    tbl[7] = 32'h00013083; // load funct3=011
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1; bus.in_instr = tbl[i]; bus.in_pc = 32'h400;
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.out_illegal !== 1'b1) begin errors++; $display("FAIL ill%0d_illegal got %b want 1", i, bus.out_illegal); end
      checks++; if (bus.out_class !== 10'h000) begin errors++; $display("FAIL ill%0d_class got %h want 000", i, bus.out_class); end
      checks++; if (bus.out_rd_we !== 1'b0) begin errors++; $display("FAIL ill%0d_rd_we got %b want 0", i, bus.out_rd_we); end
      tick();
      exp_cnt++;
    end
    checks++; if (decode_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL ill_cnt got %0d want %0d", decode_cnt, exp_cnt); end
  endtask

  task automatic test_muldiv;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_instr = 32'h022081B3; bus.in_pc = 32'h500;
    tick();
    bus.in_valid = 1'b0;
`ifdef DECODE_M_EXT_EN
    checks++; if (bus.out_illegal !== 1'b0) begin errors++; $display("FAIL mul_illegal got %b want 0", bus.out_illegal); end
    checks++; if (bus.out_class !== 10'h001) begin errors++; $display("FAIL mul_class got %h want 001", bus.out_class); end
    checks++; if (bus.out_is_muldiv !== 1'b1) begin errors++; $display("FAIL mul_is_muldiv got %b want 1", bus.out_is_muldiv); end
    checks++; if (bus.out_rd !== 5'd3) begin errors++; $display("FAIL mul_rd got %0d want 3", bus.out_rd); end
    checks++; if (bus.out_rd_we !== 1'b1) begin errors++; $display("FAIL mul_rd_we got %b want 1", bus.out_rd_we); end
`else
    checks++; if (bus.out_illegal !== 1'b1) begin errors++; $display("FAIL mul_illegal got %b want 1", bus.out_illegal); end
    checks++; if (bus.out_class !== 10'h000) begin errors++; $display("FAIL mul_class got %h want 000", bus.out_class); end
    checks++; if (bus.out_rd_we !== 1'b0) begin errors++; $display("FAIL mul_rd_we got %b want 0", bus.out_rd_we); end
`endif
    tick();
    exp_cnt++;
  endtask

  task automatic test_back_to_back;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_instr = 32'h00700113; bus.in_pc = 32'h600;
    tick();
    checks++; if (bus.out_rd !== 5'd2) begin errors++; $display("FAIL b2b_a_rd got %0d want 2", bus.out_rd); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b want 1", bus.in_ready); end
    bus.in_instr = 32'h002081B3; bus.in_pc = 32'h604;
    tick();
    exp_cnt++;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd3) begin errors++; $display("FAIL b2b_b got valid=%b rd=%0d want 1/3", bus.out_valid, bus.out_rd); end
    checks++; if (decode_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL b2b_cnt got %0d want %0d", decode_cnt, exp_cnt); end
    tick();
    exp_cnt++;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'h00700113; bus.in_pc = 32'h700;
    tick();
    bus.in_instr = 32'h002081B3; bus.in_pc = 32'h704;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", bus.in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd2 || bus.out_imm !== XLEN'(32'd7) || bus.out_pc !== 32'h700)
        begin errors++; $display("FAIL bp_hold%0d got valid=%b rd=%0d imm=%h pc=%h want 1/2/7/700", i, bus.out_valid, bus.out_rd, bus.out_imm, bus.out_pc); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall%0d_in_ready got %b want 0", i, bus.in_ready); end
    end
    checks++; if (decode_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL bp_cnt_stall got %0d want %0d", decode_cnt, exp_cnt); end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", bus.in_ready); end
    tick();
    exp_cnt++;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_class !== 10'h001 || bus.out_rd !== 5'd3 || bus.out_pc !== 32'h704) begin errors++; $display("FAIL bp_second got class=%h rd=%0d pc=%h want 001/3/704", bus.out_class, bus.out_rd, bus.out_pc); end
    checks++; if (bus.out_rs1 !== 5'd1 || bus.out_rs2 !== 5'd2 || bus.out_funct3 !== 3'd0 || bus.out_funct7 !== 7'd0)
      begin errors++; $display("FAIL bp_fields got rs1=%0d rs2=%0d f3=%0d f7=%0d want 1/2/0/0", bus.out_rs1, bus.out_rs2, bus.out_funct3, bus.out_funct7); end
    checks++; if (bus.out_imm !== '0) begin errors++; $display("FAIL bp_alu_reg_imm got %h want 0", bus.out_imm); end
    tick();
    exp_cnt++;
    checks++; if (decode_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL bp_cnt got %0d want %0d", decode_cnt, exp_cnt); end
  endtask

  task automatic test_flush;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'h00700113; bus.in_pc = 32'h800;
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid got %b want 1", bus.out_valid); end
    flush = 1'b1; bus.out_ready = 1'b1; bus.in_instr = 32'h002081B3; bus.in_pc = 32'h804;
    tick();
    flush = 1'b0; bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_rd !== 5'd2) begin errors++; $display("FAIL flush_dropped_input got rd=%0d want 2", bus.out_rd); end
    checks++; if (decode_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL flush_cnt got %0d want %0d", decode_cnt, exp_cnt); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_after got %b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid_stall;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'hFFDFF0EF; bus.in_pc = 32'h900;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid got %b want 1", bus.out_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_class !== 10'h000 || bus.out_imm !== '0 || bus.out_rd !== 5'd0 || bus.out_pc !== '0 || bus.out_rd_we !== 1'b0)
      begin errors++; $display("FAIL rstmid_fields got class=%h imm=%h rd=%0d pc=%h we=%b want all 0", bus.out_class, bus.out_imm, bus.out_rd, bus.out_pc, bus.out_rd_we); end
    checks++; if (decode_cnt !== '0) begin errors++; $display("FAIL rstmid_cnt got %0d want 0", decode_cnt); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b want 1", bus.in_ready); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_formats();
    test_illegal();
    test_muldiv();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered RV32I instruction decode stage with a valid/ready handshake on both sides. It sits between the fetch stage and the register-file/execute stage. It classifies the opcode, extracts register IDs and funct fields, and selects and sign-extends the format-specific immediate to XLEN. It flags illegal encodings and keeps a count of decoded instructions.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; immediates are sign-extended to XLEN (RV64-only opcodes still decode as illegal)
PC_W, 32, width of the PC carried alongside the instruction
CNT_W, 32, width of the decoded-instruction counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage can accept this cycle
in_instr  in  32  raw instruction word
in_pc  in  PC_W  PC of in_instr
flush  in  1  discard held and incoming instruction
out_valid  out  1  decoded bundle valid
out_ready  in  1  downstream accepts bundle
out_pc  out  PC_W  registered PC
out_class  out  10  one-hot: ALU_REG, ALU_IMM, BRANCH, JALR, JAL, AUIPC, LUI, LOAD, STORE, SYSTEM (bit 0..9)
out_rd  out  5  instr[11:7]
out_rs1  out  5  instr[19:15]
out_rs2  out  5  instr[24:20]
out_funct3  out  3  instr[14:12]
out_funct7  out  7  instr[31:25]
out_imm  out  XLEN  sign-extended immediate for the class (I/S/B/U/J); 0 for ALU_REG/SYSTEM-with-no-imm
out_rd_we  out  1  instruction writes rd and rd != 0
out_illegal  out  1  illegal encoding; out_class all zero
decode_cnt  out  CNT_W  instructions delivered downstream

Behaviour:
- Reset (synchronous, active-high): out_valid=0; all out_* data fields=0; decode_cnt=0. Reset mid-transfer discards the held bundle.
- in_ready = !out_valid || out_ready. This is combinational and registered-output; there is no skid buffer. Throughput is 1/cycle when out_ready=1.
- Accept when in_valid && in_ready && !flush. On the next edge: out_valid=1 and the decoded fields are registered. Latency is 1 cycle.
- When out_valid && out_ready && no new accept: out_valid=0 on the next edge. Data fields hold their last value.
- While out_valid && !out_ready: all outputs stay stable.
- flush has priority over everything. On the next edge out_valid=0, and an input presented in the same cycle is dropped. decode_cnt does not increment for the flushed bundle.
- decode_cnt increments by 1 on each out_valid && out_ready && !flush. It wraps modulo 2^CNT_W.
- Immediates follow the RV32 formats. I={instr[31:20]}; S={instr[31:25],instr[11:7]}; B={instr[31],instr[7],instr[30:25],instr[11:8],0}; U={instr[31:12],12'b0}; J={instr[31],instr[19:12],instr[20],instr[30:21],0}. Each is sign-extended from instr[31] to XLEN.
- Immediate format by class: ALU_IMM/JALR/LOAD/SYSTEM use I; STORE uses S; BRANCH uses B; LUI/AUIPC use U; JAL uses J.
- out_rd_we is 1 for ALU_REG, ALU_IMM, JAL, JALR, AUIPC, LUI and LOAD when rd != 0; otherwise 0. It is forced to 0 when illegal.
- out_illegal=1 for any of the following:
  - instr[1:0] != 2'b11
  - unknown opcode
  - ALU_REG with funct7 not in {0000000, 0100000}, or 0100000 with funct3 not in {000, 101}
  - SLLI with funct7 != 0, or SRLI/SRAI with funct7 not in {0, 0100000}
  - BRANCH with funct3 010 or 011
  - LOAD with funct3 in {011, 110, 111}
  - STORE with funct3 >= 011
  - JALR with funct3 != 000
- FENCE (0001111) decodes as ALU_IMM with rd_we=0. It is the only extra opcode accepted.

Optional Feature:
DECODE_M_EXT_EN:
- Defined: ALU_REG with funct7=0000001 is legal for every funct3 (MUL..REMU). out_class=ALU_REG, and an extra port out_is_muldiv (1 bit) is asserted.
- Undefined: that encoding is illegal and the port is absent.

Decomposition:
- Package decoder_pkg holds:
  - opcode localparams (OP_ALU_REG=7'b0110011, etc.)
  - class bit indices CLS_*
  - the immediate-format enum (IMM_I/S/B/U/J/NONE)
  - the funct7 constants
- One sub-module, decode_comb: a purely combinational instr -> fields/class/imm/illegal/rd_we core.
- decode_stage adds the handshake register, flush and the counter.

Test Plan:
- addi x1,x0,5 (0x00500093), out_ready=1 -> next cycle out_valid=1, class=ALU_IMM, rd=1, imm=5, rd_we=1, illegal=0; decode_cnt=1 after handshake.
- jal x1,-4 (0xFFDFF0EF) -> class=JAL, imm=0xFFFFFFFC (XLEN=64: 0xFFFFFFFFFFFFFFFC), rd_we=1.
- Backpressure: two valid instrs with out_ready=0 for 3 cycles -> in_ready=0, first bundle held stable; on release both delivered in order, decode_cnt=2.
- 0x00000000 and opcode 0x7F -> illegal=1, class=0, rd_we=0; sw with funct3=011 -> illegal=1.
- flush asserted with out_valid=1 and in_valid=1 -> next cycle out_valid=0, decode_cnt unchanged; rst asserted mid-stall -> all outputs 0.
- mul x3,x1,x2 (0x022081B3) -> with DECODE_M_EXT_EN: legal, ALU_REG, out_is_muldiv=1, rd=3; without: illegal=1.
